// File: rtl/tdc_meas_seq.sv
// Purpose: arms the TDC on a start pulse, stores up to HIT_MAX stop-hit timestamps, and enforces a timeout window.
// Latency: all outputs are registered. start -> ARM +1, tdc_arm +2; last hit -> int_done +1; rd_req -> rd_vld/rd_data +1.
// Backpressure: none. Hits past the target are dropped, and a start outside IDLE is dropped and flagged in sts_overrun.
//
// Ports:
//   clk_osc, rst                       clock and synchronous active-high reset
//   cfg_en, cfg_hit_num, cfg_timeout   SPI configuration: enable, requested hit count, window length minus 1
//   start_pulse                        synchronised measurement start
//   tdc_arm                            TDC enable, high only while measuring
//   tdc_hit_vld, tdc_hit_data          hit strobe and timestamp from the TDC core
//   int_clr                            clears int_done/int_err (and sts_overrun)
//   rd_req, rd_idx                     buffer readout request
//   rd_vld, rd_data                    buffer readout response
//   int_done, int_err                  INT0 / INT1
//   hit_cnt, sts_partial, sts_overrun  status
module tdc_meas_seq #(
    parameter int HIT_MAX = 4,
    parameter int TW      = 16,
    parameter int TO_W    = 16
) (
    input  logic                         clk_osc,
    input  logic                         rst,
    input  logic                         cfg_en,
    input  logic [$clog2(HIT_MAX):0]     cfg_hit_num,
    input  logic [TO_W-1:0]              cfg_timeout,
    input  logic                         start_pulse,
    output logic                         tdc_arm,
    input  logic                         tdc_hit_vld,
    input  logic [TW-1:0]                tdc_hit_data,
    input  logic                         int_clr,
    input  logic                         rd_req,
    input  logic [$clog2(HIT_MAX)-1:0]   rd_idx,
    output logic                         rd_vld,
    output logic [TW-1:0]                rd_data,
    output logic                         int_done,
    output logic                         int_err,
    output logic [$clog2(HIT_MAX):0]     hit_cnt,
    output logic                         sts_partial,
    output logic                         sts_overrun
);

    localparam int IW = $clog2(HIT_MAX);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_DONE, S_ERR} state_t;

    state_t          state;
    logic [TO_W-1:0] timer;
    logic [TW-1:0]   hit_buf [HIT_MAX];
    logic [CW-1:0]   tgt;
    logic [CW-1:0]   cnt_nx;
    logic            hit_ok;

    // Effective target: requests of zero mean one hit; oversize requests clamp to the buffer depth.
    always_comb begin
        tgt = cfg_hit_num;
        if (cfg_hit_num == '0) begin
            tgt = CW'(1);
        end else if (cfg_hit_num > CW'(HIT_MAX)) begin
            tgt = CW'(HIT_MAX);
        end
    end

    assign hit_ok = (state == S_MEAS) && tdc_hit_vld && (hit_cnt < tgt);
    // The count including a hit in this cycle drives both the completion and the expiry decision.
    assign cnt_nx = hit_cnt + {{(CW-1){1'b0}}, hit_ok};

    // The buffer has no reset. Entries at or above hit_cnt are never returned.
    always_ff @(posedge clk_osc) begin
        if (!rst && hit_ok) begin
            hit_buf[hit_cnt[IW-1:0]] <= tdc_hit_data;
        end
    end

    always_ff @(posedge clk_osc) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            tdc_arm     <= 1'b0;
            rd_vld      <= 1'b0;
            rd_data     <= '0;
            int_done    <= 1'b0;
            int_err     <= 1'b0;
            hit_cnt     <= '0;
            sts_partial <= 1'b0;
            sts_overrun <= 1'b0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_data <= ({1'b0, rd_idx} < hit_cnt) ? hit_buf[rd_idx] : '0;
            end

            // A clear takes priority over a start arriving in the same cycle.
            if (int_clr) begin
                sts_overrun <= 1'b0;
            end else if (start_pulse && (state != S_IDLE)) begin
                sts_overrun <= 1'b1;
            end

            if (hit_ok) begin
                hit_cnt <= cnt_nx;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_en && start_pulse) begin
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    hit_cnt     <= '0;
                    sts_partial <= 1'b0;
                    timer       <= cfg_timeout;
                    tdc_arm     <= 1'b1;
                    state       <= S_MEAS;
                end
                S_MEAS: begin
                    if (!cfg_en) begin
                        tdc_arm <= 1'b0;
                        state   <= S_IDLE;
                    end else if (hit_ok && (cnt_nx == tgt)) begin
                        tdc_arm  <= 1'b0;
                        int_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (timer == '0) begin
                        tdc_arm <= 1'b0;
                        if (cnt_nx != '0) begin
                            sts_partial <= 1'b1;
                            int_done    <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            int_err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end else begin
                        timer <= timer - TO_W'(1);
                    end
                end
                S_DONE: begin
                    if (int_clr) begin
                        int_done <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (int_clr) begin
                        int_err <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    tdc_arm <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Purpose: self-checking bench for tdc_meas_seq, combining a table of measurement scenarios, random scenarios and corner sequences.
// Latency: inputs are driven 1 ns after each rising edge and outputs are sampled at the same point.
// Backpressure: not applicable.
module tb_tdc_meas_seq;

    logic        clk_osc = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic [2:0]  cfg_hit_num = '0;
    logic [15:0] cfg_timeout = '0;
    logic        start_pulse = 1'b0;
    logic        tdc_arm;
    logic        tdc_hit_vld = 1'b0;
    logic [15:0] tdc_hit_data = '0;
    logic        int_clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_idx = '0;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic        int_done;
    logic        int_err;
    logic [2:0]  hit_cnt;
    logic        sts_partial;
    logic        sts_overrun;

    int checks = 0;
    int failures = 0;

    tdc_meas_seq #(.HIT_MAX(4), .TW(16), .TO_W(16)) dut (
        .clk_osc(clk_osc), .rst(rst), .cfg_en(cfg_en), .cfg_hit_num(cfg_hit_num),
        .cfg_timeout(cfg_timeout), .start_pulse(start_pulse), .tdc_arm(tdc_arm),
        .tdc_hit_vld(tdc_hit_vld), .tdc_hit_data(tdc_hit_data), .int_clr(int_clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_data(rd_data),
        .int_done(int_done), .int_err(int_err), .hit_cnt(hit_cnt),
        .sts_partial(sts_partial), .sts_overrun(sts_overrun)
    );

    always #5 clk_osc = ~clk_osc;

    typedef struct {
        string       name;
        logic [2:0]  hit_num;
        logic [15:0] timeout;
        logic [31:0] hit_mask;   // bit k: a hit in the k-th MEAS cycle
        logic        exp_done;
        logic        exp_err;
        logic [2:0]  exp_cnt;
        logic        exp_partial;
        int          exp_end;    // cycle, relative to the start cycle, in which the interrupt is first seen
    } vec_t;

    task automatic step();
        @(posedge clk_osc);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic do_read(input string nm, input int idx, input logic [15:0] expd);
        rd_req = 1'b1;
        rd_idx = 2'(idx);
        step();
        rd_req = 1'b0;
        chk($sformatf("%s_rdvld%0d", nm, idx), rd_vld, 1);
        chk($sformatf("%s_rddat%0d", nm, idx), rd_data, expd);
        step();
        chk($sformatf("%s_rdvld_lo%0d", nm, idx), rd_vld, 0);
        chk($sformatf("%s_rdhold%0d", nm, idx), rd_data, expd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Outcome of one measurement, derived directly from the hit times and the window length.
    function automatic void model(input logic [2:0] hn, input logic [15:0] to, input logic [31:0] mask,
                                  output logic ed, output logic ee, output logic [2:0] cnt,
                                  output logic ep, output int eend);
        int n;
        int seen;
        n = (hn == 0) ? 1 : ((hn > 4) ? 4 : int'(hn));
        seen = 0;
        eend = -1;
        for (int p = 0; p <= int'(to) && p < 32; p++) begin
            if (mask[p]) begin
                seen++;
                if (seen == n) begin
                    eend = p + 3;
                    break;
                end
            end
        end
        if (eend >= 0) begin
            ed = 1'b1; ee = 1'b0; cnt = 3'(n); ep = 1'b0;
        end else begin
            eend = int'(to) + 3;
            cnt = 3'(seen);
            ed = (seen > 0);
            ee = (seen == 0);
            ep = (seen > 0);
        end
    endfunction

    task automatic run_meas(input vec_t v);
        logic [15:0] exp_buf [4];
        logic [15:0] d;
        int n_eff;
        int stored;
        int end_at;
        n_eff = (v.hit_num == 0) ? 1 : ((v.hit_num > 4) ? 4 : int'(v.hit_num));
        stored = 0;
        end_at = -1;
        for (int i = 0; i < 4; i++) exp_buf[i] = 16'h0;
        cfg_hit_num = v.hit_num;
        cfg_timeout = v.timeout;
        start_pulse = 1'b1;
        step();                                  // T+1: ARM
        start_pulse = 1'b0;
        chk({v.name, "_arm_lo"}, tdc_arm, 0);
        step();                                  // T+2: first MEAS cycle
        for (int c = 2; c < int'(v.timeout) + 8; c++) begin
            if (int_done || int_err) begin
                end_at = c;
                break;
            end
            chk($sformatf("%s_arm_hi%0d", v.name, c), tdc_arm, 1);
            if ((c - 2) < 32 && v.hit_mask[c-2]) begin
                d = 16'($urandom);
                tdc_hit_vld = 1'b1;
                tdc_hit_data = d;
                if (stored < n_eff) begin
                    exp_buf[stored] = d;
                    stored++;
                end
            end
            step();
            tdc_hit_vld = 1'b0;
        end
        if (end_at < 0) begin
            failures++;
            checks++;
            $display("FAIL %s_no_end: no interrupt within bound, expected at T+%0d", v.name, v.exp_end);
            do_reset();
            return;
        end
        chk({v.name, "_end"}, end_at, v.exp_end);
        chk({v.name, "_done"}, int_done, v.exp_done);
        chk({v.name, "_err"}, int_err, v.exp_err);
        chk({v.name, "_cnt"}, hit_cnt, v.exp_cnt);
        chk({v.name, "_partial"}, sts_partial, v.exp_partial);
        chk({v.name, "_arm_off"}, tdc_arm, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(v.name, i, (i < int'(v.exp_cnt)) ? exp_buf[i] : 16'h0);
        end
        chk({v.name, "_int_held"}, {int_done, int_err}, {v.exp_done, v.exp_err});
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        chk({v.name, "_clr"}, {int_done, int_err}, 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        vec_t rv;
        tbl[0] = '{"full",      3'd3, 16'd100, 32'h0000_0488, 1'b1, 1'b0, 3'd3, 1'b0, 13};
        tbl[1] = '{"partial",   3'd4, 16'd10,  32'h0000_0400, 1'b1, 1'b0, 3'd1, 1'b1, 13};
        tbl[2] = '{"nohit",     3'd1, 16'd5,   32'h0000_0000, 1'b0, 1'b1, 3'd0, 1'b0, 8};
        tbl[3] = '{"zero_tgt",  3'd0, 16'd20,  32'h0000_0014, 1'b1, 1'b0, 3'd1, 1'b0, 5};
        tbl[4] = '{"clamp",     3'd7, 16'd20,  32'h0000_003f, 1'b1, 1'b0, 3'd4, 1'b0, 6};
        tbl[5] = '{"exact_exp", 3'd2, 16'd3,   32'h0000_000a, 1'b1, 1'b0, 3'd2, 1'b0, 6};
        tbl[6] = '{"to_zero",   3'd1, 16'd0,   32'h0000_0000, 1'b0, 1'b1, 3'd0, 1'b0, 3};

        // Reset values.
        rst = 1'b1;
        step();
        step();
        chk("rst_arm", tdc_arm, 0);
        chk("rst_rdvld", rd_vld, 0);
        chk("rst_rddata", rd_data, 0);
        chk("rst_ints", {int_done, int_err}, 0);
        chk("rst_cnt", hit_cnt, 0);
        chk("rst_sts", {sts_partial, sts_overrun}, 0);
        rst = 1'b0;
        step();

        // A start while disabled is ignored and does not flag an overrun.
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        step();
        step();
        chk("dis_arm", tdc_arm, 0);
        chk("dis_ovr", sts_overrun, 0);
        cfg_en = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_meas(tbl[i]);

        for (int r = 0; r < 30; r++) begin
            rv.name = $sformatf("rnd%0d", r);
            rv.hit_num = 3'($urandom_range(0, 7));
            rv.timeout = 16'($urandom_range(0, 20));
            rv.hit_mask = $urandom & $urandom;
            model(rv.hit_num, rv.timeout, rv.hit_mask, rv.exp_done, rv.exp_err,
                  rv.exp_cnt, rv.exp_partial, rv.exp_end);
            run_meas(rv);
        end

        // Overrun, dropped hits, and a clear racing a start in DONE.
        cfg_hit_num = 3'd7;
        cfg_timeout = 16'd30;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        step();                                  // T+2 MEAS
        start_pulse = 1'b1;
        tdc_hit_vld = 1'b1;
        tdc_hit_data = 16'hA000;
        step();
        start_pulse = 1'b0;
        chk("ovr_set", sts_overrun, 1);
        for (int k = 1; k < 6; k++) begin
            tdc_hit_data = 16'hA000 + 16'(k);
            step();
        end
        tdc_hit_vld = 1'b0;
        chk("ovr_done", int_done, 1);
        chk("ovr_cnt", hit_cnt, 4);
        chk("ovr_sticky", sts_overrun, 1);
        for (int i = 0; i < 4; i++) do_read("ovr", i, 16'hA000 + 16'(i));
        start_pulse = 1'b1;
        int_clr = 1'b1;
        step();
        start_pulse = 1'b0;
        int_clr = 1'b0;
        chk("race_ovr", sts_overrun, 0);
        chk("race_done", int_done, 0);
        step();
        step();
        chk("race_no_arm", tdc_arm, 0);
        chk("race_ovr2", sts_overrun, 0);

        // Abort by disabling mid-measurement.
        cfg_hit_num = 3'd4;
        cfg_timeout = 16'd50;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        step();                                  // offset 0
        step();                                  // offset 1
        tdc_hit_vld = 1'b1;
        tdc_hit_data = 16'hB001;
        step();                                  // offset 2
        tdc_hit_vld = 1'b0;
        step();                                  // offset 3
        tdc_hit_vld = 1'b1;
        tdc_hit_data = 16'hB003;
        step();                                  // offset 4
        tdc_hit_vld = 1'b0;
        cfg_en = 1'b0;
        step();
        chk("abort_arm", tdc_arm, 0);
        chk("abort_cnt", hit_cnt, 2);
        chk("abort_ints", {int_done, int_err}, 0);
        cfg_en = 1'b1;
        step();
        step();
        step();
        chk("abort_idle", {tdc_arm, int_done, int_err}, 0);
        do_read("abort", 0, 16'hB001);
        do_read("abort", 1, 16'hB003);
        do_read("abort", 2, 16'h0);

        // Reset in the middle of a measurement.
        cfg_hit_num = 3'd3;
        cfg_timeout = 16'd40;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        step();
        tdc_hit_vld = 1'b1;
        tdc_hit_data = 16'hC0DE;
        step();
        tdc_hit_vld = 1'b0;
        step();
        chk("mrst_pre_arm", tdc_arm, 1);
        rst = 1'b1;
        step();
        chk("mrst_arm_now", tdc_arm, 0);
        chk("mrst_cnt_now", hit_cnt, 0);
        step();
        rst = 1'b0;
        step();
        chk("mrst_arm", tdc_arm, 0);
        chk("mrst_ints", {int_done, int_err}, 0);
        chk("mrst_cnt", hit_cnt, 0);
        chk("mrst_sts", {sts_partial, sts_overrun}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_meas_seq.md
Name: tdc_meas_seq

Overview:
Measurement sequencer for the TDC datapath. It arms the TDC on a measurement start, collects up to HIT_MAX stop-hit timestamps into a local buffer, and enforces a configurable timeout. It raises the done or error interrupt lines (chip INT0/INT1) and serves hit readout to the SPI register block. It sits inside chip_top, between the start-pulse synchroniser, the TDC core and the SPI register file.

Parameters:
HIT_MAX, 4, hit buffer depth (max hits per measurement); power of two, >=2
TW, 16, TDC timestamp width in bits
TO_W, 16, timeout counter width in bits

Ports:
clk_osc  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_en  in  1  sequencer enable (SPI register)
cfg_hit_num  in  clog2(HIT_MAX)+1  requested hits per measurement
cfg_timeout  in  TO_W  measurement window length in cycles, minus 1
start_pulse  in  1  single-cycle synchronised TDC_start
tdc_arm  out  1  TDC enable; high only in MEAS
tdc_hit_vld  in  1  single-cycle hit strobe from the TDC
tdc_hit_data  in  TW  timestamp, valid with tdc_hit_vld
int_clr  in  1  single-cycle interrupt clear (SPI write)
rd_req  in  1  readout request pulse
rd_idx  in  clog2(HIT_MAX)  buffer index to read
rd_vld  out  1  readout data valid pulse
rd_data  out  TW  readout timestamp
int_done  out  1  measurement-complete interrupt (INT0)
int_err  out  1  no-hit timeout interrupt (INT1)
hit_cnt  out  clog2(HIT_MAX)+1  hits stored in the current or last measurement
sts_partial  out  1  DONE reached by timeout with 0 < hit_cnt < target
sts_overrun  out  1  sticky flag: start_pulse arrived while not in IDLE

Behaviour:
- Reset (rst high at a clock edge): state=IDLE. tdc_arm, rd_vld, int_done, int_err, sts_partial, sts_overrun = 0. hit_cnt=0. rd_data=0. Buffer contents are don't-care.
- Effective target N = 1 if cfg_hit_num==0; HIT_MAX if cfg_hit_num>HIT_MAX; otherwise cfg_hit_num.
- States: IDLE, ARM, MEAS, DONE, ERR. All outputs are registered.
- IDLE: if cfg_en && start_pulse -> ARM. If cfg_en==0, start_pulse is ignored and no flag is set.
- ARM (exactly 1 cycle):
  - hit_cnt=0, sts_partial=0
  - timer loads cfg_timeout
  - -> MEAS
- Timing: start at cycle T, ARM at T+1, MEAS and tdc_arm=1 at T+2.
- MEAS:
  - Each tdc_hit_vld writes buf[hit_cnt]=tdc_hit_data and increments hit_cnt. This applies only while hit_cnt<N; later hits are dropped.
  - If the hit makes hit_cnt==N -> DONE next cycle.
  - Otherwise, if timer==0 -> DONE with sts_partial=1 when hit_cnt (including a hit in the same cycle) >0, else -> ERR.
  - Otherwise the timer decrements.
  - The window therefore lasts cfg_timeout+1 cycles. A hit in the expiry cycle is stored and counted before the decision.
  - cfg_en low in MEAS -> IDLE next cycle: no interrupt, buffer and hit_cnt retained.
- tdc_arm falls in the cycle the state leaves MEAS.
- DONE: int_done=1 (held). int_clr -> IDLE and int_done=0 on the next cycle.
- ERR: int_err=1 (held). int_clr -> IDLE and int_err=0 on the next cycle.
- int_clr outside DONE/ERR is ignored.
- start_pulse in ARM, MEAS, DONE or ERR: ignored, sts_overrun=1. sts_overrun clears only on int_clr (any state) or reset. A simultaneous start_pulse and int_clr in DONE: int_clr wins, the start is dropped, and sts_overrun ends at 0.
- Readout:
  - rd_req at cycle C -> rd_vld=1 for exactly one cycle at C+1.
  - rd_data = buf[rd_idx] if rd_idx<hit_cnt, else 0.
  - Allowed in any state. During MEAS it returns hits stored up to cycle C.
  - rd_data holds its value until the next rd_req.
- hit_cnt and the buffer persist across IDLE until the next ARM.
- Reset mid-operation returns everything to reset values on the next edge; tdc_arm drops immediately at that edge.

Test Plan:
- Reset: hold rst 2 cycles mid-MEAS -> tdc_arm=0, int_done=0, int_err=0, hit_cnt=0 on the following cycle.
- Full capture: cfg_hit_num=3, cfg_timeout=100, start at T, hits 0x0011/0x0022/0x0033 at T+5/T+9/T+12 -> tdc_arm high T+2..T+12, int_done=1 at T+13, hit_cnt=3, sts_partial=0. Reads of idx 0..2 return 0x0011, 0x0022, 0x0033 one cycle after rd_req; idx 3 returns 0.
- Partial timeout: cfg_hit_num=4, cfg_timeout=10, one hit 0x1234 at T+12 (expiry cycle) -> hit stored, int_done=1 at T+13, hit_cnt=1, sts_partial=1.
- No-hit timeout: cfg_timeout=5, no hits -> int_err=1 at T+8, tdc_arm low from T+8. int_clr at T+10 -> int_err=0 at T+11, state IDLE.
- Overrun and clamp: cfg_hit_num=7 (HIT_MAX=4), 6 hits plus a start_pulse during MEAS -> hit_cnt=4, extra hits dropped, sts_overrun=1 until int_clr. A start and int_clr in the same cycle in DONE -> sts_overrun=0, no new ARM.
- Abort: cfg_en dropped in MEAS after 2 hits -> IDLE next cycle, no interrupt, hit_cnt=2, buffer readable.
